mio_bus_ctrl: RTL and testbench

Parametrised, wait-state-capable successor of the CPU memory/IO bus decoder. Sits between the CPU data port and `NSLV` slaves (data RAM, GPIO, counter, keyboard, display, ...), decodes the top address bits into a one-hot slave select, and runs a registered request/ready/ack handshake with per-access timeout and bus-error reporting. Replaces the purely combinational decode; slaves may now stretch accesses.

---
 rtl/mio_bus_pkg.sv | 21 ++
 rtl/mio_addr_decode.sv | 27 ++
 rtl/mio_bus_ctrl.sv | 137 +++++++++++++
 tb/tb_mio_bus_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_bus_pkg.sv
// Shared types and default slot map for the CPU memory/IO bus controller.
package mio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_RESP
  } bus_state_e;

  localparam logic [3:0] TAG_RAM  = 4'h0;
  localparam logic [3:0] TAG_VGA  = 4'hc;
  localparam logic [3:0] TAG_KBD  = 4'hd;
  localparam logic [3:0] TAG_SEG  = 4'he;
  localparam logic [3:0] TAG_GPIO = 4'hf;
  localparam logic [3:0] TAG_AUX  = 4'hb;

  // Slot i lives at bits [i*4 +: 4], so slot 0 (RAM) is the rightmost entry.
  localparam logic [23:0] DEF_SLV_TAGS =
    {TAG_AUX, TAG_GPIO, TAG_SEG, TAG_KBD, TAG_VGA, TAG_RAM};

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational address-tag decoder: one-hot slot select plus hit flag.
module mio_addr_decode
  import mio_bus_pkg::*;
#(
  parameter int                     NSLV     = 6,
  parameter int                     TAGW     = 4,
  parameter logic [NSLV*TAGW-1:0]   SLV_TAGS = DEF_SLV_TAGS
) (
  input  logic [TAGW-1:0] tag,
  output logic [NSLV-1:0] sel,
  output logic            hit
);

  // Scan from the top down so the lowest matching slot overwrites the rest.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (tag == SLV_TAGS[i*TAGW +: TAGW]) begin
        sel    = '0;
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// CPU bus controller: tag decode, registered req/ready/ack handshake with
// per-access wait-state timeout and bus-error reporting.
module mio_bus_ctrl
  import mio_bus_pkg::*;
#(
  parameter int                     NSLV     = 6,
  parameter int                     AW       = 32,
  parameter int                     DW       = 32,
  parameter int                     TAGW     = 4,
  parameter logic [NSLV*TAGW-1:0]   SLV_TAGS = DEF_SLV_TAGS,
  parameter int                     TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_wdata,
  output logic                 cpu_ack,
  output logic                 cpu_err,
  output logic [DW-1:0]        cpu_rdata,
  output logic                 busy,
  output logic [AW-1:0]        err_addr,
  output logic [NSLV-1:0]      slv_sel,
  output logic                 slv_we,
  output logic [AW-1:0]        slv_addr,
  output logic [DW-1:0]        slv_wdata,
  input  logic [NSLV*DW-1:0]   slv_rdata,
  input  logic [NSLV-1:0]      slv_rdy
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  WAIT_MAX = CW'(TIMEOUT);

  bus_state_e       state;
  logic [CW-1:0]    wait_cnt;
  logic [NSLV-1:0]  dec_sel;
  logic             dec_hit;
  logic             sel_rdy;
  logic [DW-1:0]    sel_rdata;

  mio_addr_decode #(
    .NSLV     (NSLV),
    .TAGW     (TAGW),
    .SLV_TAGS (SLV_TAGS)
  ) u_decode (
    .tag (cpu_addr[AW-1 -: TAGW]),
    .sel (dec_sel),
    .hit (dec_hit)
  );

  // slv_sel is one-hot or zero, so OR-ing the gated slots is the read mux.
  always_comb begin
    sel_rdy   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (slv_sel[i]) begin
        sel_rdy   = sel_rdy | slv_rdy[i];
        sel_rdata = sel_rdata | slv_rdata[i*DW +: DW];
      end
    end
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      err_addr  <= '0;
      slv_sel   <= '0;
      slv_we    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cpu_ack <= 1'b0;
          if (cpu_req) begin
            slv_addr  <= cpu_addr;
            slv_wdata <= cpu_wdata;
            if (dec_hit) begin
              slv_sel  <= dec_sel;
              slv_we   <= cpu_we;
              wait_cnt <= '0;
              state    <= ST_ACC;
            end else begin
              cpu_ack   <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
              err_addr  <= cpu_addr;
              state     <= ST_RESP;
            end
          end
        end

        // Ready beats timeout when both land in the same cycle.
        ST_ACC: begin
          if (sel_rdy) begin
            cpu_rdata <= slv_we ? '0 : sel_rdata;
            cpu_err   <= 1'b0;
            cpu_ack   <= 1'b1;
            slv_sel   <= '0;
            slv_we    <= 1'b0;
            state     <= ST_RESP;
          end else if (wait_cnt == WAIT_MAX) begin
            cpu_rdata <= '0;
            cpu_err   <= 1'b1;
            cpu_ack   <= 1'b1;
            err_addr  <= slv_addr;
            slv_sel   <= '0;
            slv_we    <= 1'b0;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          cpu_ack <= 1'b0;
          state   <= ST_IDLE;
        end

        default: begin
          cpu_ack <= 1'b0;
          slv_sel <= '0;
          slv_we  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl with a transaction-level timeline model.
module tb_mio_bus_ctrl;

  localparam int NS = 6;
  localparam int TO = 15;
  localparam int NC = 1024;
  localparam logic [3:0] SLOT_TAG [NS] = '{4'h0, 4'hc, 4'hd, 4'he, 4'hf, 4'hb};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cpu_req, cpu_we;
  logic [31:0]   cpu_addr, cpu_wdata;
  logic          cpu_ack, cpu_err, busy, slv_we;
  logic [31:0]   cpu_rdata, err_addr, slv_addr, slv_wdata;
  logic [5:0]    slv_sel, slv_rdy;
  logic [191:0]  slv_rdata;

  mio_bus_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .busy(busy),
    .err_addr(err_addr), .slv_sel(slv_sel), .slv_we(slv_we),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_rdata(slv_rdata),
    .slv_rdy(slv_rdy)
  );

  // Second instance with duplicated tags to pin lowest-index priority.
  logic          d_req, d_we, d_ack, d_err, d_busy, d_swe;
  logic [31:0]   d_addr, d_wdata, d_rdata, d_err_addr, d_saddr, d_swdata;
  logic [1:0]    d_sel, d_srdy;
  logic [63:0]   d_srdata;

  mio_bus_ctrl #(.NSLV(2), .TIMEOUT(2), .SLV_TAGS(8'h33)) dup (
    .clk(clk), .rst(rst), .cpu_req(d_req), .cpu_we(d_we),
    .cpu_addr(d_addr), .cpu_wdata(d_wdata), .cpu_ack(d_ack),
    .cpu_err(d_err), .cpu_rdata(d_rdata), .busy(d_busy),
    .err_addr(d_err_addr), .slv_sel(d_sel), .slv_we(d_swe),
    .slv_addr(d_saddr), .slv_wdata(d_swdata), .slv_rdata(d_srdata),
    .slv_rdy(d_srdy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit done  = 1'b0;

  int           wait_cfg [NS];
  logic [31:0]  rd_cfg   [NS];
  logic [5:0]   rdy_noise;
  int           sel_cnt  [NS];

  // Bench slaves: slot i raises ready after wait_cfg[i] selected cycles (-1 = never).
  always @(posedge clk)
    for (int i = 0; i < NS; i++) sel_cnt[i] <= slv_sel[i] ? sel_cnt[i] + 1 : 0;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      slv_rdy[i] = rdy_noise[i] |
                   (slv_sel[i] && wait_cfg[i] >= 0 && sel_cnt[i] >= wait_cfg[i]);
      slv_rdata[i*32 +: 32] = rd_cfg[i];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Expected per-cycle timeline, filled one access at a time.
  bit        e_ack [NC], e_err [NC], e_we [NC], e_busy [NC], e_rst [NC];
  bit [5:0]  e_sel [NC];
  bit [31:0] e_rd [NC], e_ea [NC], e_addr [NC], e_wd [NC];
  int        free_at = 0;

  function automatic int slot_of(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (a[31:28] == SLOT_TAG[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int n, s, d;
    bit er;
    bit [31:0] rd;
    n = cyc;
    if (rst) begin
      for (int c = n + 1; c < n + 48 && c < NC; c++) begin
        e_ack[c] = 0; e_err[c] = 0; e_we[c] = 0; e_busy[c] = 0; e_sel[c] = 0;
        e_rd[c] = 0; e_ea[c] = 0; e_addr[c] = 0; e_wd[c] = 0; e_rst[c] = 0;
      end
      e_rst[n+1] = 1;
      free_at = n + 1;
    end else if (cpu_req && n >= free_at) begin
      s = slot_of(cpu_addr);
      if (s < 0) begin
        e_ack[n+1] = 1; e_err[n+1] = 1; e_rd[n+1] = 0; e_ea[n+1] = cpu_addr;
        e_busy[n+1] = 1;
        free_at = n + 2;
      end else begin
        if (wait_cfg[s] >= 0 && wait_cfg[s] <= TO) begin
          d = wait_cfg[s]; er = 0; rd = cpu_we ? 32'h0 : rd_cfg[s];
        end else begin
          d = TO; er = 1; rd = 0;
        end
        for (int c = n + 1; c <= n + 1 + d; c++) begin
          e_sel[c] = 6'b1 << s; e_we[c] = cpu_we; e_busy[c] = 1;
          e_addr[c] = cpu_addr; e_wd[c] = cpu_wdata;
        end
        e_ack[n+2+d] = 1; e_err[n+2+d] = er; e_rd[n+2+d] = rd;
        e_ea[n+2+d] = cpu_addr; e_busy[n+2+d] = 1;
        free_at = n + 3 + d;
      end
    end
    cyc = n + 1;
  end

  bit [31:0] h_rd = 0;
  bit [31:0] h_ea = 0;

  always @(negedge clk) begin : compare
    int c;
    c = cyc;
    if (!done && c >= 1 && c < NC) begin
      if (e_rst[c]) begin h_rd = 0; h_ea = 0; end
      if (e_ack[c]) begin
        h_rd = e_rd[c];
        if (e_err[c]) h_ea = e_ea[c];
      end
      checkOutput("ack", 32'(cpu_ack), 32'(e_ack[c]));
      checkOutput("busy", 32'(busy), 32'(e_busy[c]));
      checkOutput("sel", 32'(slv_sel), 32'(e_sel[c]));
      checkOutput("slv_we", 32'(slv_we), 32'(e_we[c]));
      checkOutput("rdata", cpu_rdata, h_rd);
      checkOutput("err_addr", err_addr, h_ea);
      if (e_ack[c]) checkOutput("err", 32'(cpu_err), 32'(e_err[c]));
      if (e_sel[c] != 0) begin
        checkOutput("slv_addr", slv_addr, e_addr[c]);
        checkOutput("slv_wdata", slv_wdata, e_wd[c]);
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wd, output int lat,
                               output logic [5:0] first_sel);
    int start;
    lat = -1;
    first_sel = 'x;
    @(negedge clk);
    start = cyc;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        cpu_req = 1'b0;
        first_sel = slv_sel;
      end
      if (cpu_ack) begin
        lat = cyc - start;
        break;
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("[TB] FAIL ack_wait addr %h: got no ack want ack within 40 cycles", addr);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, s, n_ack, first_ack;
    int ack_c [3];
    logic [5:0] fs;

    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; rdy_noise = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_srdy = 2'b11;
    d_srdata = {32'hBBBB_0001, 32'hAAAA_0000};
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = 0;
      rd_cfg[i] = 32'h1111_0000 * (i + 1);
    end
    rd_cfg[0] = 32'hDEAD_BEEF;
    rd_cfg[3] = 32'h3333_0003;

    repeat (3) @(negedge clk);
    checkOutput("rst_ack", 32'(cpu_ack), 0);
    checkOutput("rst_err", 32'(cpu_err), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_sel", 32'(slv_sel), 0);
    checkOutput("rst_we", 32'(slv_we), 0);
    checkOutput("rst_rdata", cpu_rdata, 0);
    checkOutput("rst_err_addr", err_addr, 0);
    checkOutput("rst_slv_addr", slv_addr, 0);
    checkOutput("rst_slv_wdata", slv_wdata, 0);
    rst = 0;

    $display("[TB] zero-wait read of slot 0");
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, lat, fs);
    checkOutput("rd0_lat", 32'(lat), 2);
    checkOutput("rd0_sel", 32'(fs), 32'h01);
    checkOutput("rd0_rdata", cpu_rdata, 32'hDEAD_BEEF);
    checkOutput("rd0_err", 32'(cpu_err), 0);

    $display("[TB] write to slot 4 with 3 wait states");
    wait_cfg[4] = 3;
    applyStimulus(1'b1, 32'hF000_0000, 32'h0000_1234, lat, fs);
    checkOutput("wr4_lat", 32'(lat), 5);
    checkOutput("wr4_sel", 32'(fs), 32'h10);
    checkOutput("wr4_err", 32'(cpu_err), 0);
    checkOutput("wr4_rdata", cpu_rdata, 0);

    $display("[TB] unmapped read");
    applyStimulus(1'b0, 32'h5000_0000, 32'h0, lat, fs);
    checkOutput("um_lat", 32'(lat), 1);
    checkOutput("um_sel", 32'(fs), 0);
    checkOutput("um_err", 32'(cpu_err), 1);
    checkOutput("um_err_addr", err_addr, 32'h5000_0000);
    checkOutput("um_rdata", cpu_rdata, 0);

    $display("[TB] slot 3 timeout with ready noise on other slots");
    wait_cfg[3] = -1;
    rdy_noise = 6'b110111;
    applyStimulus(1'b0, 32'hE000_0000, 32'h0, lat, fs);
    rdy_noise = 0;
    checkOutput("to_lat", 32'(lat), 17);
    checkOutput("to_err", 32'(cpu_err), 1);
    checkOutput("to_err_addr", err_addr, 32'hE000_0000);

    $display("[TB] slot 3 ready on the last wait cycle");
    wait_cfg[3] = TO;
    applyStimulus(1'b0, 32'hE000_0004, 32'h0, lat, fs);
    checkOutput("last_lat", 32'(lat), 17);
    checkOutput("last_err", 32'(cpu_err), 0);
    checkOutput("last_rdata", cpu_rdata, 32'h3333_0003);
    checkOutput("last_err_addr_hold", err_addr, 32'hE000_0000);

    $display("[TB] request held across three reads");
    @(negedge clk);
    s = cyc; n_ack = 0;
    cpu_we = 0; cpu_addr = 32'h0000_0020; cpu_req = 1;
    for (int i = 0; i < 30 && n_ack < 3; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        ack_c[n_ack] = cyc;
        n_ack++;
        if (n_ack == 3) cpu_req = 0;
      end
    end
    cpu_req = 0;
    checkOutput("held_acks", 32'(n_ack), 3);
    checkOutput("held_first", 32'(ack_c[0] - s), 2);
    checkOutput("held_gap1", 32'(ack_c[1] - ack_c[0]), 3);
    checkOutput("held_gap2", 32'(ack_c[2] - ack_c[1]), 3);

    $display("[TB] request pulse during ACC is ignored");
    wait_cfg[1] = 2;
    @(negedge clk);
    s = cyc; n_ack = 0; first_ack = -1;
    cpu_addr = 32'hC000_0000; cpu_req = 1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) cpu_req = 0;
      if (i == 2) begin cpu_req = 1; cpu_addr = 32'hD000_0000; end
      if (i == 3) cpu_req = 0;
      if (cpu_ack) begin
        n_ack++;
        if (first_ack < 0) first_ack = cyc - s;
      end
    end
    checkOutput("pulse_acks", 32'(n_ack), 1);
    checkOutput("pulse_lat", 32'(first_ack), 4);

    $display("[TB] reset in the middle of an access");
    wait_cfg[3] = -1;
    @(negedge clk);
    cpu_addr = 32'hE000_0008; cpu_req = 1;
    @(negedge clk);
    cpu_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checkOutput("mid_rst_sel", 32'(slv_sel), 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_ack", 32'(cpu_ack), 0);
    checkOutput("mid_rst_err_addr", err_addr, 0);
    repeat (20) @(negedge clk);

    $display("[TB] duplicate tags pick the lowest slot");
    @(negedge clk);
    d_addr = 32'h3000_0040; d_req = 1;
    @(negedge clk);
    d_req = 0;
    checkOutput("dup_sel", 32'(d_sel), 32'h1);
    @(negedge clk);
    checkOutput("dup_ack", 32'(d_ack), 1);
    checkOutput("dup_err", 32'(d_err), 0);
    checkOutput("dup_rdata", d_rdata, 32'hAAAA_0000);

    repeat (3) @(negedge clk);
    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
